// File: rtl/elastic_stage_chain.sv
// Elastic valid/ack pipeline of DEPTH data stages with a combinational ready path across the
// chain, per-stage capture enables, registered occupancy and a synchronous flush.
module elastic_stage_chain #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ack,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ack,
  output logic [DATA_W-1:0] out_data,
  output logic [DEPTH-1:0]  cap,
  output logic [CNT_W-1:0]  occupancy
);

  logic [DEPTH-1:0]  full_q, full_d;
  logic [DEPTH-1:0]  adv;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [CNT_W-1:0]  occ_q, occ_d;
  logic              en;

  assign en = rst_n & ~flush;

  always_comb begin
    adv    = '0;
    cap    = '0;
    full_d = '0;
    occ_d  = '0;
    in_ack = 1'b0;

    // Advance resolves from the consumer end back so a full chain still moves when out_ack is high.
    adv[DEPTH-1] = full_q[DEPTH-1] & out_ack;
    for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
      adv[i] = full_q[i] & (~full_q[i+1] | adv[i+1]);
    end

    in_ack = en & (~full_q[0] | adv[0]);
    cap[0] = in_ack & in_valid;
    for (int i = 1; i < int'(DEPTH); i++) begin
      cap[i] = en & full_q[i-1] & (~full_q[i] | adv[i]);
    end

    for (int i = 0; i < int'(DEPTH); i++) begin
      full_d[i] = cap[i] | (full_q[i] & ~adv[i]);
      occ_d     = occ_d + CNT_W'(full_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q <= '0;
      occ_q  <= '0;
    end else if (flush) begin
      full_q <= '0;
      occ_q  <= '0;
    end else begin
      full_q <= full_d;
      occ_q  <= occ_d;
    end
  end

  // Data only moves on cap, which is already low during reset and flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= '0;
      end
    end else begin
      if (cap[0]) begin
        data_q[0] <= in_data;
      end
      for (int i = 1; i < int'(DEPTH); i++) begin
        if (cap[i]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign out_valid = full_q[DEPTH-1] & rst_n;
  assign out_data  = data_q[DEPTH-1];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_elastic_stage_chain.sv
// Bench for elastic_stage_chain: queue-of-items reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_elastic_stage_chain;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ack;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ack = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [DEPTH-1:0]  cap;
  logic [CNT_W-1:0]  occupancy;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  elastic_stage_chain #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ack   (in_ack),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ack  (out_ack),
    .out_data (out_data),
    .cap      (cap),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: ordered list of items in flight, each with the stage it occupies. Each cycle the
  // oldest item leaves from the last stage on out_ack; every other item steps forward when
  // the stage ahead is free or being vacated; a new item enters stage 0 if it is free then.
  typedef struct {
    logic [DATA_W-1:0] d;
    int                pos;
  } item_t;

  item_t mq[$];
  item_t nq[$];

  always @(negedge clk) begin : cmp
    int               n;
    bit               mv [16];
    bit               ov, ia;
    logic [DEPTH-1:0] ecap;
    item_t            it;
    n    = mq.size();
    ecap = '0;
    for (int k = 0; k < n; k++) begin
      if (k == 0) mv[k] = (mq[k].pos == int'(DEPTH) - 1) ? out_ack : 1'b1;
      else        mv[k] = (mq[k].pos + 1 < mq[k-1].pos) || mv[k-1];
    end
    ov = rst_n && n > 0 && mq[0].pos == int'(DEPTH) - 1;
    ia = rst_n && !flush && (n == 0 || mq[n-1].pos != 0 || mv[n-1]);
    if (rst_n && !flush) begin
      for (int k = 0; k < n; k++) begin
        if (mv[k] && mq[k].pos < int'(DEPTH) - 1) ecap[mq[k].pos + 1] = 1'b1;
      end
      if (in_valid && ia) ecap[0] = 1'b1;
    end
    if (chk_en) begin
      chk("m_out_valid", 32'(out_valid), 32'(ov));
      chk("m_in_ack", 32'(in_ack), 32'(ia));
      chk("m_cap", 32'(cap), 32'(ecap));
      chk("m_occupancy", 32'(occupancy), 32'(n));
      if (ov) chk("m_out_data", 32'(out_data), 32'(mq[0].d));
    end
    nq = {};
    if (rst_n && !flush) begin
      for (int k = 0; k < n; k++) begin
        if (!(mv[k] && mq[k].pos == int'(DEPTH) - 1)) begin
          it.d   = mq[k].d;
          it.pos = mv[k] ? mq[k].pos + 1 : mq[k].pos;
          nq.push_back(it);
        end
      end
      if (in_valid && ia) begin
        it.d   = in_data;
        it.pos = 0;
        nq.push_back(it);
      end
    end
    mq = nq;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic latency_test(input logic [DATA_W-1:0] d);
    int first;
    first    = -1;
    in_valid = 1'b1;
    in_data  = d;
    out_ack  = 1'b1;
    @(negedge clk);
    chk("lat_accept", 32'(in_ack), 32'd1);
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) chk("lat_occ_one", 32'(occupancy), 32'd1);
      if (out_valid && first < 0) begin
        first = k;
        chk("lat_data", 32'(out_data), 32'(d));
      end
      if (k == 5) chk("lat_occ_zero", 32'(occupancy), 32'd0);
      tick();
    end
    chk("lat_cycles", 32'(first), 32'd4);
  endtask

  initial begin
    logic [DATA_W-1:0] rx[$];
    int                acks;
    bit                acc;

    tick();
    chk_en = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    @(negedge clk);
    chk("rst_in_ack", 32'(in_ack), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_cap", 32'(cap), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    tick();
    rst_n    = 1'b1;
    in_valid = 1'b0;

    // Single item end to end.
    latency_test(8'h5A);

    // Full-throughput stream.
    acks     = 0;
    in_valid = 1'b1;
    out_ack  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = DATA_W'(i + 1);
      @(negedge clk);
      if (in_ack) acks++;
      if (out_valid) rx.push_back(out_data);
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) rx.push_back(out_data);
      tick();
    end
    chk("stream_acks", 32'(acks), 32'd16);
    chk("stream_count", 32'(rx.size()), 32'd16);
    for (int i = 0; i < rx.size(); i++) chk("stream_item", 32'(rx[i]), 32'(i + 1));

    // Fill with the consumer stalled.
    out_ack  = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = DATA_W'(8'hA0 + i);
      tick();
    end
    in_data = 8'hA4;
    @(negedge clk);
    chk("full_in_ack", 32'(in_ack), 32'd0);
    chk("full_occ", 32'(occupancy), 32'd4);
    chk("full_out_data", 32'(out_data), 32'hA0);
    tick();
    out_ack = 1'b1;
    @(negedge clk);
    chk("pulse_in_ack", 32'(in_ack), 32'd1);
    tick();
    out_ack  = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("pulse_occ", 32'(occupancy), 32'd4);
    chk("pulse_out_data", 32'(out_data), 32'hA1);
    tick();

    // Drain one, then flush with three held and an offer pending.
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    @(negedge clk);
    chk("pre_flush_occ", 32'(occupancy), 32'd3);
    tick();
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hB0;
    out_ack  = 1'b1;
    @(negedge clk);
    chk("flush_in_ack", 32'(in_ack), 32'd0);
    chk("flush_cap", 32'(cap), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd1);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_flush_occ", 32'(occupancy), 32'd0);
    chk("post_flush_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 5; i++) tick();

    // Reset mid-stream.
    in_valid = 1'b1;
    out_ack  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = DATA_W'(8'hC0 + i);
      tick();
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ack", 32'(in_ack), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_cap", 32'(cap), 32'd0);
    tick();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_occ", 32'(occupancy), 32'd0);
    tick();
    latency_test(8'h3C);

    // Random traffic; the model checks every cycle. Offered data holds until accepted.
    in_valid = 1'b0;
    acc      = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (!in_valid || acc) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = DATA_W'($urandom);
      end
      out_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = in_valid && in_ack;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
